// File: rtl/sba_mem_responder.sv
// sba_mem_responder
//   Responder for the debug module's system-bus-access master, speaking the
//   req/gnt/r_valid protocol. One access is outstanding at a time; the
//   backing store is a flop-based word memory that clears on reset.
//
// Ports
//   clk_i     rising-edge clock
//   rst_i     asynchronous, active-high reset
//   req_i     request valid from the SBA master
//   we_i      1 = write, 0 = read
//   addr_i    byte address (low byte-offset bits ignored)
//   wdata_i   write data
//   be_i      byte enables for writes
//   gnt_o     grant, combinational from req_i while idle
//   rvalid_o  one-cycle response strobe (reads and writes)
//   rdata_o   read data, zero whenever rvalid_o is low
//   err_o     out-of-range flag, qualified by rvalid_o
//   busy_o    high while an accepted access waits for its response
module sba_mem_responder #(
  parameter int unsigned AddrWidth   = 16,
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned NumWords    = 64,
  parameter int unsigned BaseAddr    = 'h0,
  parameter int unsigned RespLatency = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_i,
  input  logic                   we_i,
  input  logic [AddrWidth-1:0]   addr_i,
  input  logic [DataWidth-1:0]   wdata_i,
  input  logic [DataWidth/8-1:0] be_i,
  output logic                   gnt_o,
  output logic                   rvalid_o,
  output logic [DataWidth-1:0]   rdata_o,
  output logic                   err_o,
  output logic                   busy_o
);

  localparam int unsigned NumBytes = DataWidth / 8;
  localparam int unsigned OffBits  = $clog2(NumBytes);
  localparam int unsigned IdxWidth = $clog2(NumWords);

  localparam logic [AddrWidth-1:0] BaseA     = AddrWidth'(BaseAddr);
  localparam logic [AddrWidth:0]   NumWordsA = (AddrWidth + 1)'(NumWords);
  localparam logic [1:0]           CntLoad   = 2'(RespLatency - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e state_reg, state_next;

  logic                 borrow;
  logic [AddrWidth-1:0] off;
  logic [AddrWidth-1:0] idx;
  logic                 in_range;
  logic                 accept;
  logic [IdxWidth-1:0]  widx;
  logic [DataWidth-1:0] merged;

  logic [DataWidth-1:0] mem [NumWords];
  logic [1:0]           cnt_reg;
  logic [DataWidth-1:0] rd_word_reg;
  logic                 err_reg;

  // The subtraction borrow says addr_i < BaseAddr, so an underflowed offset
  // can never look like a small in-range index.
  assign {borrow, off} = {1'b0, addr_i} - {1'b0, BaseA};
  assign idx      = off >> OffBits;
  assign in_range = !borrow && ({1'b0, idx} < NumWordsA);
  assign widx     = idx[IdxWidth-1:0];
  assign accept   = (state_reg == IDLE) && req_i;

  // Byte-lane merge of the new write data over the currently stored word.
  for (genvar gi = 0; gi < NumBytes; gi++) begin : g_lane
    assign merged[gi*8 +: 8] = be_i[gi] ? wdata_i[gi*8 +: 8] : mem[widx][gi*8 +: 8];
  end

  // Writes land at acceptance, so a later read always sees them.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NumWords; i++) begin
        mem[i] <= '0;
      end
    end else if (accept && we_i && in_range) begin
      mem[widx] <= merged;
    end
  end

  // Because the write is already applied, only the response contents need
  // to be held across the latency window.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_word_reg <= '0;
      err_reg     <= 1'b0;
    end else if (accept) begin
      err_reg     <= !in_range;
      rd_word_reg <= (!we_i && in_range) ? mem[widx] : '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_reg <= '0;
    end else if (accept) begin
      cnt_reg <= CntLoad;
    end else if (state_reg == WAIT && cnt_reg != 2'd0) begin
      cnt_reg <= cnt_reg - 2'd1;
    end
  end

  // Response outputs are registered on the WAIT->RESP edge and forced back
  // to zero on every other edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rvalid_o <= 1'b0;
      rdata_o  <= '0;
      err_o    <= 1'b0;
    end else if (state_reg == WAIT && cnt_reg == 2'd0) begin
      rvalid_o <= 1'b1;
      rdata_o  <= rd_word_reg;
      err_o    <= err_reg;
    end else begin
      rvalid_o <= 1'b0;
      rdata_o  <= '0;
      err_o    <= 1'b0;
    end
  end

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (req_i) state_next = WAIT;
      WAIT:    if (cnt_reg == 2'd0) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    gnt_o  = 1'b0;
    busy_o = 1'b0;
    unique case (state_reg)
      IDLE:    gnt_o  = req_i;
      WAIT:    busy_o = 1'b1;
      default: begin
        gnt_o  = 1'b0;
        busy_o = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_sba_mem_responder.sv
// Bench for sba_mem_responder: four instances (RespLatency 1..4, one with a
// non-zero base address), each driven by its own stimulus process. Expected
// responses come from a word-array reference model and are queued at
// acceptance; a per-instance monitor pops and compares on every rvalid.
`timescale 1ns/1ps
module tb_sba_mem_responder;

  localparam int N  = 4;
  localparam int NW = 64;
  localparam int RL_TAB   [N] = '{1, 2, 3, 4};
  localparam int BASE_TAB [N] = '{0, 0, 'h1000, 0};

  typedef struct {
    logic        err;
    logic [31:0] data;
    int          t;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  logic [N-1:0] done;

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d: got %h want %h (cycle %0d)", nm, d, act, exp, cyc);
    end
  endtask

  for (genvar gi = 0; gi < N; gi++) begin : g_dut
    localparam int RL   = RL_TAB[gi];
    localparam int BASE = BASE_TAB[gi];

    logic        rst;
    logic        req;
    logic        we;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
    logic        busy;
    logic        done_l = 1'b0;

    exp_t        q[$];
    logic [31:0] mdl [NW];
    int          t_last;

    assign done[gi] = done_l;

    sba_mem_responder #(
      .AddrWidth  (16),
      .DataWidth  (32),
      .NumWords   (NW),
      .BaseAddr   (BASE),
      .RespLatency(RL)
    ) u_dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .req_i   (req),
      .we_i    (we),
      .addr_i  (addr),
      .wdata_i (wdata),
      .be_i    (be),
      .gnt_o   (gnt),
      .rvalid_o(rvalid),
      .rdata_o (rdata),
      .err_o   (err),
      .busy_o  (busy)
    );

    // Reference model: plain byte-address arithmetic over a word array.
    task automatic apply(input logic w, input logic [15:0] a, input logic [31:0] d, input logic [3:0] b);
      exp_t e;
      int   ua;
      int   wi;
      ua     = int'(a);
      e.t    = cyc;
      e.data = 32'h0;
      e.err  = 1'b1;
      if (ua >= BASE && (ua - BASE) / 4 < NW) begin
        wi    = (ua - BASE) / 4;
        e.err = 1'b0;
        if (w) begin
          for (int k = 0; k < 4; k++) begin
            if (b[k]) mdl[wi][8*k +: 8] = d[8*k +: 8];
          end
        end else begin
          e.data = mdl[wi];
        end
      end
      q.push_back(e);
    endtask

    // Presents a request and waits for its grant; leaves req high so the
    // caller can chain back-to-back accesses.
    task automatic issue(input logic w, input logic [15:0] a, input logic [31:0] d,
                         input logic [3:0] b, input bit gap);
      int n;
      n = 0;
      req = 1'b1; we = w; addr = a; wdata = d; be = b;
      @(negedge clk);
      while (!gnt && n < 40) begin
        @(negedge clk);
        n++;
      end
      if (!gnt) begin
        chk("grant_timeout", gi, {31'b0, gnt}, 32'h1);
      end else begin
        if (gap) chk("accept_gap", gi, cyc - t_last, RL + 2);
        t_last = cyc;
        apply(w, a, d, b);
      end
      @(posedge clk);
      #1;
    endtask

    task automatic idle(input int n);
      req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0;
      repeat (n) @(posedge clk);
      #1;
    endtask

    initial begin
      logic [15:0] a;
      logic        w;
      logic [31:0] d;
      logic [3:0]  b;
      int          r;
      bit          held;
      rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0;
      t_last = 0;
      held   = 1'b0;
      for (int i = 0; i < NW; i++) mdl[i] = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_rvalid", gi, {31'b0, rvalid}, 32'h0);
      chk("rst_rdata",  gi, rdata, 32'h0);
      chk("rst_err",    gi, {31'b0, err}, 32'h0);
      chk("rst_busy",   gi, {31'b0, busy}, 32'h0);
      chk("rst_gnt",    gi, {31'b0, gnt}, 32'h0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // write then read back
      issue(1'b1, 16'(BASE + 'h8), 32'hDEADBEEF, 4'hF, 1'b0); idle(1);
      issue(1'b0, 16'(BASE + 'h8), 32'h0, 4'h0, 1'b0);        idle(1);
      // partial write, then be=0 no-op, with req held throughout
      issue(1'b1, 16'(BASE + 'h4), 32'h11223344, 4'hF, 1'b0);
      issue(1'b1, 16'(BASE + 'h4), 32'hAABBCCDD, 4'b0101, 1'b1);
      issue(1'b1, 16'(BASE + 'h4), 32'hFFFFFFFF, 4'h0, 1'b1);
      issue(1'b0, 16'(BASE + 'h4), 32'h0, 4'h0, 1'b1);       idle(2);
      // out of range: one past the top, write there, then below the base
      issue(1'b0, 16'(BASE + 'h100), 32'h0, 4'h0, 1'b0);
      issue(1'b1, 16'(BASE + 'h100), 32'h12345678, 4'hF, 1'b1);
      issue(1'b0, 16'(BASE + 'h0), 32'h0, 4'h0, 1'b1);
      issue(1'b0, 16'(BASE - 4), 32'h0, 4'h0, 1'b1);
      issue(1'b0, 16'(BASE + 'hFC), 32'h0, 4'h0, 1'b1);      idle(1);
      // misaligned read hits the containing word
      issue(1'b1, 16'(BASE + 'h10), 32'hCAFEF00D, 4'hF, 1'b0);
      issue(1'b0, 16'(BASE + 'h13), 32'h0, 4'h0, 1'b1);      idle(1);

      // reset while a read is waiting: its response must never appear
      issue(1'b1, 16'(BASE + 'h20), 32'h5A5AA5A5, 4'hF, 1'b0); idle(1);
      issue(1'b0, 16'(BASE + 'h20), 32'h0, 4'h0, 1'b0);
      req = 1'b0;
      if (RL >= 2) begin
        @(posedge clk);
        #1;
      end
      rst = 1'b1;
      q.delete();
      for (int i = 0; i < NW; i++) mdl[i] = 32'h0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_rvalid", gi, {31'b0, rvalid}, 32'h0);
      chk("post_rst_rdata",  gi, rdata, 32'h0);
      chk("post_rst_err",    gi, {31'b0, err}, 32'h0);
      chk("post_rst_busy",   gi, {31'b0, busy}, 32'h0);
      @(posedge clk);
      #1;
      issue(1'b0, 16'(BASE + 'h20), 32'h0, 4'h0, 1'b0);
      issue(1'b0, 16'(BASE + 'h8), 32'h0, 4'h0, 1'b1);       idle(1);

      // random traffic, mostly on a small window so reads hit written words
      for (int i = 0; i < 50; i++) begin
        r = int'($urandom_range(0, 9));
        if (r == 0)      a = 16'(BASE + NW * 4 + int'($urandom_range(0, 63)));
        else if (r == 1) a = 16'(BASE - 1 - int'($urandom_range(0, 15)));
        else if (r == 2) a = 16'(BASE + NW * 4 - 4 + int'($urandom_range(0, 3)));
        else             a = 16'(BASE + int'($urandom_range(0, 63)));
        w = 1'($urandom_range(0, 1));
        d = $urandom;
        b = 4'($urandom_range(0, 15));
        issue(w, a, d, b, held);
        if ($urandom_range(0, 2) == 0) begin
          held = 1'b1;
        end else begin
          held = 1'b0;
          idle(int'($urandom_range(1, 3)));
        end
      end
      idle(RL + 4);
      chk("drained", gi, q.size(), 32'h0);
      done_l = 1'b1;
    end

    // Monitor: handshake/busy shape every cycle, response contents on rvalid.
    always @(negedge clk) begin : mon
      exp_t e;
      if (!rst) begin
        if (q.size() > 0 && cyc > q[0].t) begin
          chk("gnt_low", gi, {31'b0, gnt}, 32'h0);
          chk("busy", gi, {31'b0, busy}, (cyc <= q[0].t + RL) ? 32'h1 : 32'h0);
        end else begin
          chk("busy_idle", gi, {31'b0, busy}, 32'h0);
        end
        if (rvalid) begin
          if (q.size() == 0) begin
            chk("spurious_rvalid", gi, {31'b0, rvalid}, 32'h0);
          end else begin
            e = q.pop_front();
            chk("rdata", gi, rdata, e.data);
            chk("err", gi, {31'b0, err}, {31'b0, e.err});
            chk("resp_cycle", gi, cyc, e.t + RL + 1);
          end
        end else begin
          chk("quiet_rdata", gi, rdata, 32'h0);
          chk("quiet_err", gi, {31'b0, err}, 32'h0);
        end
      end
    end
  end

  initial begin
    int n;
    n = 0;
    while (done != {N{1'b1}} && n < 20000) begin
      @(posedge clk);
      n++;
    end
    if (done != {N{1'b1}}) chk("sim_timeout", 0, {28'b0, done}, 32'hF);
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sba_mem_responder.md
Name: sba_mem_responder

Overview:
Responder for the debug module's system-bus-access (SBA) master port, using the req/gnt/r_valid protocol. It serves one outstanding access at a time from a flop-based word memory, with byte-enabled writes, programmable response latency and out-of-range error signalling. It sits where the DM SBA master connects to a local scratchpad, so JTAG can write and read back system memory without an AXI fabric.

Parameters:
AddrWidth, 16, width of addr_i in bits.
DataWidth, 32, data width in bits; must be 32 or 64.
NumWords, 64, memory depth in DataWidth words; must be ≥ 2.
BaseAddr, 'h0, byte address of word 0.
RespLatency, 1, cycles from acceptance to response; legal range 1..4.

Ports:
clk_i  in  1  clock; all state updates on the rising edge.
rst_i  in  1  reset, asynchronous, active-high.
req_i  in  1  request valid from the SBA master.
we_i  in  1  1 = write, 0 = read.
addr_i  in  AddrWidth  byte address.
wdata_i  in  DataWidth  write data.
be_i  in  DataWidth/8  byte enables for writes.
gnt_o  out  1  grant; the request is accepted in a cycle where req_i && gnt_o.
rvalid_o  out  1  one-cycle response strobe, for reads and writes.
rdata_o  out  DataWidth  read data; meaningful only when rvalid_o is high.
err_o  out  1  error flag, qualified by rvalid_o.
busy_o  out  1  high while an accepted access is awaiting its response.

Behaviour:
- Reset values (rst_i high): state IDLE, latency counter 0, rvalid_o 0, rdata_o 0, err_o 0, busy_o 0, all memory words 0. Reset acts immediately and asynchronously.
- FSM states:
  - IDLE: gnt_o = req_i, combinational. On acceptance, capture we_i, addr_i, wdata_i and be_i; load the counter with RespLatency-1; go to WAIT.
  - WAIT: gnt_o = 0, busy_o = 1.
    - Counter not 0: decrement.
    - Counter 0: go to RESP and register the response outputs on that edge.
  - RESP: rvalid_o = 1 for exactly this one cycle; gnt_o = 0; next state IDLE.
- Timing: acceptance in cycle T gives rvalid_o high in cycle T+RespLatency+1. The earliest next acceptance is T+RespLatency+2. With RespLatency=1, back-to-back accesses complete at most one every 3 cycles.
- Address decode:
  - off = addr_i - BaseAddr, computed at AddrWidth width; idx = off >> log2(DataWidth/8).
  - In range if and only if addr_i >= BaseAddr and idx < NumWords.
  - Low byte-offset bits are ignored, so a misaligned address accesses the containing word.
- Write, in range: the memory is updated at acceptance. Byte lane k is written only if be_i[k]. be_i = 0 is a legal no-op. Response: err_o 0, rdata_o 0.
- Read, in range: memory is sampled at acceptance; rdata_o returns that word in RESP, err_o 0.
- Out of range (read or write): memory is untouched; response err_o 1, rdata_o 0.
- Read-after-write: a read accepted after a write's response returns the written data.
- Outside RESP: rvalid_o 0, rdata_o 0, err_o 0.
- req_i dropped while gnt_o is low: no effect; nothing is captured.
- Reset mid-operation: a pending response is discarded and no rvalid_o pulse follows. Memory is cleared even if a write had already been applied.
- Address arithmetic never wraps into range: an addr_i below BaseAddr is out of range even if the subtraction underflows.

Test Plan:
1. Write then read, default parameters: write addr 'h8, wdata 'hDEADBEEF, be 'hF, accepted at T; later read addr 'h8 → rvalid_o at T+2 for the write with err_o 0; the read response returns rdata_o 'hDEADBEEF, err_o 0; gnt_o 0 during WAIT and RESP.
2. Partial write: preload word 'h4 = 'h11223344, then write 'hAABBCCDD with be 'b0101 → a read of 'h4 returns 'h11BB33DD. A write with be 0 leaves the word unchanged, err_o 0.
3. Out of range: read addr 'h100 (word index 64, NumWords 64) → rvalid_o with err_o 1, rdata_o 0. A write to 'h100 followed by a read of 'h0 shows 'h0 unchanged. With BaseAddr 'h1000, a read of 'h0FFC → err_o 1.
4. Latency sweep RespLatency=1..4, with req_i held high continuously → acceptances occur every RespLatency+2 cycles; exactly one rvalid_o pulse per acceptance; busy_o high from T+1 to T+RespLatency.
5. Reset mid-access: accept a read with RespLatency=3, assert rst_i at T+2 → rvalid_o never pulses for that read; after release, all outputs are 0 and a read of any previously written word returns 0.
6. Misaligned address: write 'hCAFEF00D to 'h10, then read 'h13 → rdata_o 'hCAFEF00D, err_o 0.
